// File: rtl/fifo_pkg.sv
// Shared widths, word type and pointer-wrap helper for the variable-count parallel FIFO.
package fifo_pkg;

  localparam int unsigned WORD_W = 8;

  typedef logic [WORD_W-1:0] word_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // depth is a power of two, so the wrap is a mask
  function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                           input int unsigned depth);
    return (base + off) & (depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and handshake control for var_par_fifo.
// Optional almost_full/almost_empty flags when FIFO_ALMOST_EN is defined.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PAR_WRITE = 4,
  parameter int unsigned PAR_READ  = 4
`ifdef FIFO_ALMOST_EN
  ,
  parameter int unsigned AF_LEVEL  = 6,
  parameter int unsigned AE_LEVEL  = 2
`endif
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_valid,
  input  logic [$clog2(PAR_WRITE+1)-1:0]   wr_cnt,
  input  logic                             rd_req,
  input  logic [$clog2(PAR_READ+1)-1:0]    rd_cnt,
  output logic                             wr_ready,
  output logic                             wr_fire,
  output logic                             rd_ack,
  output logic [ptr_w(DEPTH)-1:0]          wr_ptr,
  output logic [ptr_w(DEPTH)-1:0]          rd_ptr,
  output logic [cnt_w(DEPTH)-1:0]          count,
  output logic                             full,
  output logic                             empty
`ifdef FIFO_ALMOST_EN
  ,
  output logic                             almost_full,
  output logic                             almost_empty
`endif
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [CW-1:0] cnt_add;
  logic [CW-1:0] cnt_sub;

  // Both handshakes judge against the pre-cycle count: a same-cycle read frees nothing
  assign wr_ready = rst_n && (32'(wr_cnt) <= PAR_WRITE) && ((DEPTH - 32'(count)) >= 32'(wr_cnt));
  assign rd_ack   = rst_n && rd_req && (32'(rd_cnt) <= PAR_READ) && (32'(rd_cnt) <= 32'(count));
  assign wr_fire  = wr_valid && wr_ready;

  assign cnt_add = wr_fire ? CW'(wr_cnt) : '0;
  assign cnt_sub = rd_ack  ? CW'(rd_cnt) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= PW'(wrap_add(32'(wr_ptr), 32'(wr_cnt), DEPTH));
      if (rd_ack)  rd_ptr <= PW'(wrap_add(32'(rd_ptr), 32'(rd_cnt), DEPTH));
      count <= count + cnt_add - cnt_sub;
    end
  end

  assign full  = (32'(count) == DEPTH);
  assign empty = (count == '0);

`ifdef FIFO_ALMOST_EN
  assign almost_full  = (32'(count) >= AF_LEVEL);
  assign almost_empty = (32'(count) <= AE_LEVEL);
`endif

endmodule

// File: rtl/var_par_fifo.sv
// Circular word FIFO accepting 0..PAR_WRITE and retiring 0..PAR_READ words per cycle (FWFT).
// Define FIFO_ALMOST_EN to add the almost_full/almost_empty outputs.
module var_par_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PAR_WRITE  = 4,
  parameter int unsigned PAR_READ   = 4,
  parameter int unsigned AF_LEVEL   = 6,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wr_valid,
  input  logic [$clog2(PAR_WRITE+1)-1:0]        wr_cnt,
  input  logic [PAR_WRITE-1:0][DATA_WIDTH-1:0]  wr_data,
  output logic                                  wr_ready,
  input  logic                                  rd_req,
  input  logic [$clog2(PAR_READ+1)-1:0]         rd_cnt,
  output logic                                  rd_ack,
  output logic [PAR_READ-1:0][DATA_WIDTH-1:0]   rd_data,
  output logic [cnt_w(DEPTH)-1:0]               count,
  output logic                                  full,
  output logic                                  empty
`ifdef FIFO_ALMOST_EN
  ,
  output logic                                  almost_full,
  output logic                                  almost_empty
`endif
);

  localparam int unsigned PW = ptr_w(DEPTH);

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < PAR_WRITE) || (DEPTH < PAR_READ) ||
      (AE_LEVEL > AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_cfg
    $error("var_par_fifo: invalid parameter set");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  wr_fire;

  fifo_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .PAR_WRITE (PAR_WRITE),
    .PAR_READ  (PAR_READ)
`ifdef FIFO_ALMOST_EN
    ,
    .AF_LEVEL  (AF_LEVEL),
    .AE_LEVEL  (AE_LEVEL)
`endif
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_cnt       (wr_cnt),
    .rd_req       (rd_req),
    .rd_cnt       (rd_cnt),
    .wr_ready     (wr_ready),
    .wr_fire      (wr_fire),
    .rd_ack       (rd_ack),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .full         (full),
    .empty        (empty)
`ifdef FIFO_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  // Storage is deliberately not reset; occupancy masks stale words on the read side
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PAR_WRITE; i++) begin
      if (wr_fire && (i < 32'(wr_cnt)))
        mem[PW'(wrap_add(32'(wr_ptr), i, DEPTH))] <= wr_data[i];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned j = 0; j < PAR_READ; j++) begin
      if (j < 32'(count))
        rd_data[j] = mem[PW'(wrap_add(32'(rd_ptr), j, DEPTH))];
    end
  end

endmodule
